// File: rtl/pump_pkg.sv
// Shared state type, sizing constants and the one-hot helper used by the
// pump dose scheduler and its round-robin arbiter.
package pump_pkg;

    localparam int NUM_PUMPS_MAX = 8;
    localparam int PULSE_W       = 8;
    localparam int ID_W          = 3;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP
    } pump_state_e;

    function automatic logic [NUM_PUMPS_MAX-1:0] onehot(input logic [ID_W-1:0] idx);
        return NUM_PUMPS_MAX'(1) << idx;
    endfunction

endpackage

// File: rtl/pump_rr_arbiter.sv
// Combinational round-robin pick: first set candidate scanning upward from
// pointer+1 with wrap-around.
module pump_rr_arbiter
    import pump_pkg::*;
#(
    parameter int NUM_PUMPS = 3
)(
    input  logic [NUM_PUMPS-1:0] candidates_i,
    input  logic [ID_W-1:0]      pointer_i,
    output logic                 grant_valid_o,
    output logic [ID_W-1:0]      grant_idx_o
);

    int   idx;
    logic hit;

    // Walk the scan from the far end back toward pointer+1 so the last hit
    // written is the nearest one, which avoids a separate found flag.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx           = 0;
        hit           = 1'b0;
        for (int k = NUM_PUMPS; k >= 1; k--) begin
            idx = (int'(pointer_i) + k) % NUM_PUMPS;
            hit = |(candidates_i & (NUM_PUMPS'(1) << idx));
            if (hit) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pump_dose_scheduler.sv
// Serialises pump dose requests so only one pump is energised at a time,
// timing each pulse in seconds and forcing an idle gap between pulses.
module pump_dose_scheduler
    import pump_pkg::*;
#(
    parameter int NUM_PUMPS  = 3,
    parameter int CLOCK_FREQ = 1_000_000,
    parameter int GAP_CYCLES = 1000
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PUMPS-1:0] req,
    input  logic                 cancel,
    input  logic [PULSE_W-1:0]   pulse_on_time,
    output logic [NUM_PUMPS-1:0] pump_out,
    output logic [ID_W-1:0]      active_id,
    output logic                 busy,
    output logic [NUM_PUMPS-1:0] pending,
    output logic                 done
);

    localparam int PRESC_W = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLOCK_FREQ - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam pump_state_e        PULSE_END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

    pump_state_e          state_q, state_d;
    logic [NUM_PUMPS-1:0] pumpOut_q, pumpOut_d;
    logic [ID_W-1:0]      activeId_q, activeId_d;
    logic                 busy_q, busy_d;
    logic [NUM_PUMPS-1:0] pending_q, pending_d;
    logic                 done_q, done_d;
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PULSE_W-1:0]   sec_q, sec_d;
    logic [PULSE_W-1:0]   dur_q, dur_d;
    logic [GAP_W-1:0]     gap_q, gap_d;

    logic [NUM_PUMPS-1:0] candidates;
    logic [NUM_PUMPS-1:0] grantMask;
    logic                 grantValid;
    logic [ID_W-1:0]      grantIdx;
    logic                 endPulse;

    pump_rr_arbiter #(
        .NUM_PUMPS (NUM_PUMPS)
    ) u_arbiter (
        .candidates_i  (candidates),
        .pointer_i     (ptr_q),
        .grant_valid_o (grantValid),
        .grant_idx_o   (grantIdx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pumpOut_q  <= '0;
            activeId_q <= '0;
            busy_q     <= 1'b0;
            pending_q  <= '0;
            done_q     <= 1'b0;
            ptr_q      <= ID_W'(NUM_PUMPS - 1);
            presc_q    <= '0;
            sec_q      <= '0;
            dur_q      <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            pumpOut_q  <= pumpOut_d;
            activeId_q <= activeId_d;
            busy_q     <= busy_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            ptr_q      <= ptr_d;
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            dur_q      <= dur_d;
            gap_q      <= gap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pumpOut_d  = pumpOut_q;
        activeId_d = activeId_q;
        busy_d     = busy_q;
        pending_d  = pending_q;
        done_d     = 1'b0;
        ptr_d      = ptr_q;
        presc_d    = presc_q;
        sec_d      = sec_q;
        dur_d      = dur_q;
        gap_d      = gap_q;
        endPulse   = 1'b0;
        candidates = pending_q | req;
        grantMask  = NUM_PUMPS'(onehot(grantIdx));

        unique case (state_q)
            IDLE: begin
                if (grantValid && !cancel) begin
                    state_d    = ON;
                    pumpOut_d  = grantMask;
                    activeId_d = grantIdx;
                    busy_d     = 1'b1;
                    ptr_d      = grantIdx;
                    pending_d  = candidates & ~grantMask;
                    dur_d      = (pulse_on_time == '0) ? PULSE_W'(1) : pulse_on_time;
                    presc_d    = '0;
                    sec_d      = '0;
                end
            end
            ON: begin
                // A repeat request for the pump already running is discarded.
                pending_d = pending_q | (req & ~pumpOut_q);
                if (cancel) begin
                    endPulse = 1'b1;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (sec_q + PULSE_W'(1) == dur_q) begin
                        endPulse = 1'b1;
                        done_d   = 1'b1;
                    end else begin
                        sec_d = sec_q + PULSE_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
                if (endPulse) begin
                    state_d    = PULSE_END_STATE;
                    pumpOut_d  = '0;
                    activeId_d = '0;
                    busy_d     = 1'b0;
                    presc_d    = '0;
                    sec_d      = '0;
                    gap_d      = '0;
                end
            end
            GAP: begin
                pending_d = pending_q | req;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cancel) begin
            pending_d = '0;
        end
    end

    assign pump_out  = pumpOut_q;
    assign active_id = activeId_q;
    assign busy      = busy_q;
    assign pending   = pending_q;
    assign done      = done_q;

endmodule

// File: tb/tb_pump_dose_scheduler.sv
// Bench for pump_dose_scheduler: directed scenarios with literal expectations
// plus random traffic, all checked each cycle against a cycle-budget model.
module tb_pump_dose_scheduler;

    localparam int NUM_PUMPS  = 3;
    localparam int CLOCK_FREQ = 10;
    localparam int GAP_CYCLES = 4;

    logic       clk;
    logic       rstI;
    logic [2:0] reqI;
    logic       cancelI;
    logic [7:0] ptI;
    logic [2:0] pumpOut;
    logic [2:0] activeId;
    logic       busy;
    logic [2:0] pendingO;
    logic       done;

    int tests    = 0;
    int failures = 0;

    int         mOnLeft;
    int         mGapLeft;
    int         mActive;
    int         mPtr;
    logic [2:0] mPending;
    logic       mDone;

    pump_dose_scheduler #(
        .NUM_PUMPS  (NUM_PUMPS),
        .CLOCK_FREQ (CLOCK_FREQ),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk           (clk),
        .rst           (rstI),
        .req           (reqI),
        .cancel        (cancelI),
        .pulse_on_time (ptI),
        .pump_out      (pumpOut),
        .active_id     (activeId),
        .busy          (busy),
        .pending       (pendingO),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] r, input logic c, input logic rs);
        @(negedge clk);
        reqI    = r;
        cancelI = c;
        rstI    = rs;
    endtask

    // The model tracks remaining pulse and gap cycles as plain counts.
    always @(posedge clk) begin : model
        logic [2:0] cand;
        bit         found;
        int         idx;
        if (rstI) begin
            mOnLeft  = 0;
            mGapLeft = 0;
            mActive  = 0;
            mPtr     = NUM_PUMPS - 1;
            mPending = '0;
            mDone    = 1'b0;
        end else begin
            mDone = 1'b0;
            if (mOnLeft > 0) begin
                if (cancelI) begin
                    mOnLeft  = 0;
                    mPending = '0;
                    mGapLeft = GAP_CYCLES;
                end else begin
                    mPending = mPending | (reqI & ~(3'b001 << mActive));
                    mOnLeft--;
                    if (mOnLeft == 0) begin
                        mDone    = 1'b1;
                        mGapLeft = GAP_CYCLES;
                    end
                end
            end else if (mGapLeft > 0) begin
                mGapLeft--;
                mPending = cancelI ? 3'b000 : (mPending | reqI);
            end else if (cancelI) begin
                mPending = '0;
            end else begin
                cand  = mPending | reqI;
                found = 1'b0;
                for (int k = 1; k <= NUM_PUMPS; k++) begin
                    idx = (mPtr + k) % NUM_PUMPS;
                    if (!found && ((cand >> idx) & 3'b001) != 3'b000) begin
                        found   = 1'b1;
                        mActive = idx;
                    end
                end
                if (found) begin
                    mPtr     = mActive;
                    mPending = cand & ~(3'b001 << mActive);
                    mOnLeft  = ((ptI == 8'd0) ? 1 : int'(ptI)) * CLOCK_FREQ;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [2:0] expPump;
        expPump = (mOnLeft > 0) ? 3'(3'b001 << mActive) : 3'b000;
        checkOutput("pump_out", 32'(pumpOut), 32'(expPump));
        checkOutput("active_id", 32'(activeId), (mOnLeft > 0) ? 32'(mActive) : 32'd0);
        checkOutput("busy", 32'(busy), 32'(mOnLeft > 0));
        checkOutput("pending", 32'(pendingO), 32'(mPending));
        checkOutput("done", 32'(done), 32'(mDone));
        checkOutput("onehot", 32'($countones(pumpOut) <= 1), 32'd1);
    end

    task automatic serveNext(output int id, output int width);
        int n;
        n     = 0;
        id    = -1;
        width = 0;
        while (pumpOut == 3'b000 && n < 200) begin
            applyStimulus(3'b000, 1'b0, 1'b0);
            n++;
        end
        if (pumpOut == 3'b000) begin
            tests++;
            failures++;
            $display("[TB] FAIL serveNext: no grant within 200 cycles, got none, expected a grant");
        end else begin
            id = int'(activeId);
            while (pumpOut != 3'b000 && width < 200) begin
                width++;
                applyStimulus(3'b000, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        int id;
        int width;
        rstI    = 1'b1;
        reqI    = '0;
        cancelI = 1'b0;
        ptI     = 8'd2;

        applyStimulus(3'b000, 1'b0, 1'b1);
        applyStimulus(3'b000, 1'b0, 1'b1);
        checkOutput("reset pump_out", 32'(pumpOut), 32'd0);
        checkOutput("reset pending", 32'(pendingO), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);

        // Single request, two-second pulse.
        applyStimulus(3'b010, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 1'b0);
        checkOutput("single grant", 32'(pumpOut), 32'h2);
        checkOutput("single active_id", 32'(activeId), 32'd1);
        serveNext(id, width);
        checkOutput("single width", 32'(width), 32'd20);
        checkOutput("single done", 32'(done), 32'd1);
        applyStimulus(3'b000, 1'b0, 1'b0);
        checkOutput("done one cycle", 32'(done), 32'd0);

        // Simultaneous requests right at reset exit.
        ptI = 8'd1;
        applyStimulus(3'b000, 1'b0, 1'b1);
        applyStimulus(3'b111, 1'b0, 1'b0);
        serveNext(id, width);
        checkOutput("order first", 32'(id), 32'd0);
        checkOutput("one second width", 32'(width), 32'd10);
        serveNext(id, width);
        checkOutput("order second", 32'(id), 32'd1);
        serveNext(id, width);
        checkOutput("order third", 32'(id), 32'd2);

        // Round-robin wrap after pump1 has been served.
        applyStimulus(3'b010, 1'b0, 1'b0);
        serveNext(id, width);
        checkOutput("rr pump1", 32'(id), 32'd1);
        repeat (3) applyStimulus(3'b000, 1'b0, 1'b0);
        applyStimulus(3'b011, 1'b0, 1'b0);
        serveNext(id, width);
        checkOutput("rr wrap pump0", 32'(id), 32'd0);
        serveNext(id, width);
        checkOutput("rr then pump1", 32'(id), 32'd1);

        // Cancel at ON cycle 5 with pump0 pending.
        repeat (5) applyStimulus(3'b000, 1'b0, 1'b0);
        ptI = 8'd2;
        applyStimulus(3'b100, 1'b0, 1'b0);
        applyStimulus(3'b001, 1'b0, 1'b0);
        repeat (3) applyStimulus(3'b000, 1'b0, 1'b0);
        checkOutput("pre-cancel pending", 32'(pendingO), 32'h1);
        applyStimulus(3'b000, 1'b1, 1'b0);
        applyStimulus(3'b000, 1'b0, 1'b0);
        checkOutput("cancel pump_out", 32'(pumpOut), 32'd0);
        checkOutput("cancel pending", 32'(pendingO), 32'd0);
        checkOutput("cancel no done", 32'(done), 32'd0);
        repeat (10) applyStimulus(3'b000, 1'b0, 1'b0);
        checkOutput("cancel no regrant", 32'(pumpOut), 32'd0);

        // Zero duration, request for active pump, request during gap.
        ptI = 8'd0;
        applyStimulus(3'b001, 1'b0, 1'b0);
        applyStimulus(3'b001, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 1'b0);
        checkOutput("active req ignored", 32'(pendingO), 32'd0);
        serveNext(id, width);
        checkOutput("zero duration width", 32'(width + 1), 32'd10);
        applyStimulus(3'b010, 1'b0, 1'b0);
        serveNext(id, width);
        checkOutput("gap req granted", 32'(id), 32'd1);

        // Reset while a pulse is running.
        repeat (5) applyStimulus(3'b000, 1'b0, 1'b0);
        ptI = 8'd3;
        applyStimulus(3'b001, 1'b0, 1'b0);
        applyStimulus(3'b100, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 1'b0);
        checkOutput("pre-reset pending", 32'(pendingO), 32'h4);
        applyStimulus(3'b000, 1'b0, 1'b1);
        applyStimulus(3'b000, 1'b0, 1'b0);
        checkOutput("mid reset pump_out", 32'(pumpOut), 32'd0);
        checkOutput("mid reset pending", 32'(pendingO), 32'd0);
        applyStimulus(3'b100, 1'b0, 1'b0);
        applyStimulus(3'b000, 1'b0, 1'b0);
        checkOutput("post reset grant", 32'(pumpOut), 32'h4);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] r;
            r = 3'b000;
            for (int b = 0; b < NUM_PUMPS; b++) begin
                if ($urandom_range(0, 15) == 0) r = r | (3'b001 << b);
            end
            ptI = 8'($urandom_range(0, 2));
            applyStimulus(r, $urandom_range(0, 99) == 0, $urandom_range(0, 599) == 0);
        end
        repeat (3) applyStimulus(3'b000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
